// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer: synchronises and debounces the raw set/reset buttons
// and issues single-cycle, mutually exclusive set/reset pulses for the
// SR flop built around the JK cell.
// Optional build macro: SR_CONFLICT_FLAG_EN adds the sticky 'conflict'
// output that records any cycle in which both channels rose together.

// One debounce channel: 2-flop synchroniser plus a four-state acceptance FSM.
module sr_cmd_debouncer_chan #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   typedef enum logic [1:0] {IDLE, ARM_HI, HIGH, ARM_LO} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync;
   logic             syn;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   assign syn = sync[1];

   // Rise event: the edge that moves ARM_HI into HIGH. Used by the top to
   // register the pulse on the same edge the level goes high.
   assign rise = (state == ARM_HI) && syn && (cnt == CNT_LAST);

   // Two-flop synchroniser for the asynchronous button input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[0], raw};
   end

   // Debounce FSM: a level change is accepted only after the synchronised
   // input has disagreed with the current level for DEBOUNCE_CYCLES+1 edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (syn) state <= ARM_HI;
            end
            ARM_HI: begin
               if (!syn) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= HIGH;
                  level <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HIGH: begin
               cnt <= '0;
               if (!syn) state <= ARM_LO;
            end
            ARM_LO: begin
               if (syn) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE;
                  level <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               level <= 1'b0;
            end
         endcase
      end
   end

endmodule

// Top: two channels (0 = set, 1 = reset) plus pulse arbitration.
// DEBOUNCE_CYCLES must be >= 2 and 2**CNT_W must exceed DEBOUNCE_CYCLES.
module sr_cmd_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5,
   parameter int RESET_PRIORITY  = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_set_raw,
   input  logic btn_rst_raw,
   output logic set_pulse,
   output logic rst_pulse,
   output logic set_level,
   output logic rst_level
`ifdef SR_CONFLICT_FLAG_EN
   ,
   output logic conflict
`endif
);

   localparam int  NUM_CH   = 2;
   localparam logic RST_WINS = (RESET_PRIORITY != 0);

   logic [NUM_CH-1:0] raw_v;
   logic [NUM_CH-1:0] lvl_v;
   logic [NUM_CH-1:0] rise_v;
   logic              set_win;
   logic              rst_win;

   assign raw_v = {btn_rst_raw, btn_set_raw};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      sr_cmd_debouncer_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (raw_v[i]),
         .level (lvl_v[i]),
         .rise  (rise_v[i])
      );
   end

   assign set_level = lvl_v[0];
   assign rst_level = lvl_v[1];

   // Arbitration: a same-cycle double rise lets only the priority channel
   // pulse, so s and r can never be high together at the SR flop.
   always_comb begin
      set_win = rise_v[0] & ~(rise_v[1] &  RST_WINS);
      rst_win = rise_v[1] & ~(rise_v[0] & ~RST_WINS);
   end

   // Registered pulses, aligned with the level rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_pulse <= 1'b0;
         rst_pulse <= 1'b0;
      end else begin
         set_pulse <= set_win;
         rst_pulse <= rst_win;
      end
   end

`ifdef SR_CONFLICT_FLAG_EN
   logic both_q;

   // Sticky conflict flag: set one edge after a double rise, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         both_q   <= 1'b0;
         conflict <= 1'b0;
      end else begin
         both_q   <= &rise_v;
         conflict <= conflict | both_q;
      end
   end
`endif

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Testbench for sr_cmd_debouncer (DEBOUNCE_CYCLES = 4, reset priority).
// The reference model treats each channel as "flip the level once the
// synchronised input has disagreed with it for D+1 consecutive edges".
module tb_sr_cmd_debouncer;

   localparam int D    = 4;
   localparam int PRIO = 1;
   localparam int LAT  = D + 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_set_raw = 1'b0;
   logic btn_rst_raw = 1'b0;
   logic set_pulse, rst_pulse, set_level, rst_level;
`ifdef SR_CONFLICT_FLAG_EN
   logic conflict;
`endif

   int errors = 0;
   int checks = 0;

   // model state
   bit m_d1[2], m_d2[2], m_lvl[2];
   int m_run[2];
   bit m_set, m_rst, m_both, m_conf;

   sr_cmd_debouncer #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (5),
      .RESET_PRIORITY  (PRIO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_set_raw (btn_set_raw),
      .btn_rst_raw (btn_rst_raw),
      .set_pulse   (set_pulse),
      .rst_pulse   (rst_pulse),
      .set_level   (set_level),
      .rst_level   (rst_level)
`ifdef SR_CONFLICT_FLAG_EN
      ,
      .conflict    (conflict)
`endif
   );

   always #5 clk = ~clk;

   // s and r must never be high together
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (set_pulse && rst_pulse) begin
            errors++;
            $display("FAIL exclusive_pulses t=%0t got set=1 rst=1 want at most one high", $time);
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_d1[i] = 0; m_d2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
      end
      m_set = 0; m_rst = 0; m_both = 0; m_conf = 0;
   endtask

   task automatic model_edge(input bit s, input bit r);
      bit raw[2];
      bit rise[2];
      bit syn;
      if (!rst_n) begin
         model_reset();
         return;
      end
      raw[0] = s; raw[1] = r;
      for (int i = 0; i < 2; i++) begin
         syn     = m_d2[i];          // input as sampled two edges ago
         m_d2[i] = m_d1[i];
         m_d1[i] = raw[i];
         rise[i] = 0;
         if (syn != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == D + 1) begin
               m_lvl[i] = syn;
               m_run[i] = 0;
               rise[i]  = syn;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_conf = m_conf | m_both;
      m_both = rise[0] & rise[1];
      m_set  = rise[0] && !(rise[1] && PRIO != 0);
      m_rst  = rise[1] && !(rise[0] && PRIO == 0);
   endtask

   // drive raw inputs, advance one edge, update model, settle
   task automatic step(input bit s, input bit r);
      btn_set_raw = s;
      btn_rst_raw = r;
      @(posedge clk);
      model_edge(s, r);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      model_reset();
      step(1, 1);
      step(0, 1);
      checks++;
      if ({set_pulse, rst_pulse, set_level, rst_level} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_state got=%b want=0000", {set_pulse, rst_pulse, set_level, rst_level});
      end
`ifdef SR_CONFLICT_FLAG_EN
      checks++;
      if (conflict !== 1'b0) begin
         errors++;
         $display("FAIL reset_conflict got=%b want=0", conflict);
      end
`endif
      step(0, 0);
      step(0, 0);
      model_reset();
      rst_n = 1;
   endtask

   task automatic idle(input int n, input string tag);
      for (int k = 1; k <= n; k++) begin
         step(0, 0);
         checks++;
         if ({set_pulse, rst_pulse, set_level, rst_level} !== {m_set, m_rst, m_lvl[0], m_lvl[1]}) begin
            errors++;
            $display("FAIL %s_release step=%0d got=%b want=%b", tag, k,
                     {set_pulse, rst_pulse, set_level, rst_level}, {m_set, m_rst, m_lvl[0], m_lvl[1]});
         end
      end
   endtask

   task automatic test_clean_press();
      int at = -1, n = 0;
      for (int k = 1; k <= 20; k++) begin
         step(1, 0);
         if (set_pulse) begin n++; if (at < 0) at = k; end
         checks++;
         if ({set_pulse, rst_pulse, set_level, rst_level} !== {m_set, m_rst, m_lvl[0], m_lvl[1]}) begin
            errors++;
            $display("FAIL clean_press step=%0d got=%b want=%b", k,
                     {set_pulse, rst_pulse, set_level, rst_level}, {m_set, m_rst, m_lvl[0], m_lvl[1]});
         end
      end
      checks++;
      if (n !== 1 || at !== LAT) begin
         errors++;
         $display("FAIL clean_press_latency got count=%0d edge=%0d want count=1 edge=%0d", n, at, LAT);
      end
      idle(12, "clean_press");
   endtask

   task automatic test_bounce();
      bit pat[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
      int at = -1, n = 0;
      bit r;
      for (int k = 1; k <= 24; k++) begin
         r = (k <= 8) ? pat[k-1] : 1'b1;
         step(0, r);
         if (rst_pulse) begin n++; if (at < 0) at = k; end
         checks++;
         if ({set_pulse, rst_pulse, set_level, rst_level} !== {m_set, m_rst, m_lvl[0], m_lvl[1]}) begin
            errors++;
            $display("FAIL bounce step=%0d got=%b want=%b", k,
                     {set_pulse, rst_pulse, set_level, rst_level}, {m_set, m_rst, m_lvl[0], m_lvl[1]});
         end
      end
      checks++;
      if (n !== 1 || at !== 9 + LAT - 1) begin
         errors++;
         $display("FAIL bounce_latency got count=%0d edge=%0d want count=1 edge=%0d", n, at, 9 + LAT - 1);
      end
      idle(12, "bounce");
   endtask

   task automatic test_release_glitch();
      int n = 0;
      bit s;
      for (int k = 1; k <= 26; k++) begin
         s = !(k == 13 || k == 14);
         step(s, 0);
         if (set_pulse) n++;
         checks++;
         if ({set_pulse, rst_pulse, set_level, rst_level} !== {m_set, m_rst, m_lvl[0], m_lvl[1]}) begin
            errors++;
            $display("FAIL release_glitch step=%0d got=%b want=%b", k,
                     {set_pulse, rst_pulse, set_level, rst_level}, {m_set, m_rst, m_lvl[0], m_lvl[1]});
         end
      end
      checks++;
      if (n !== 1 || set_level !== 1'b1) begin
         errors++;
         $display("FAIL release_glitch_summary got pulses=%0d level=%b want pulses=1 level=1", n, set_level);
      end
      idle(12, "release_glitch");
   endtask

   task automatic test_simultaneous();
      int rat = -1, ns = 0;
      for (int k = 1; k <= 15; k++) begin
         step(1, 1);
         if (set_pulse) ns++;
         if (rst_pulse && rat < 0) rat = k;
         checks++;
         if ({set_pulse, rst_pulse, set_level, rst_level} !== {m_set, m_rst, m_lvl[0], m_lvl[1]}) begin
            errors++;
            $display("FAIL simultaneous step=%0d got=%b want=%b", k,
                     {set_pulse, rst_pulse, set_level, rst_level}, {m_set, m_rst, m_lvl[0], m_lvl[1]});
         end
`ifdef SR_CONFLICT_FLAG_EN
         checks++;
         if (conflict !== m_conf || conflict !== (k >= LAT + 1)) begin
            errors++;
            $display("FAIL simultaneous_conflict step=%0d got=%b want=%b", k, conflict, (k >= LAT + 1));
         end
`endif
      end
      checks++;
      if (ns !== 0 || rat !== LAT || {set_level, rst_level} !== 2'b11) begin
         errors++;
         $display("FAIL simultaneous_summary got set_pulses=%0d rst_edge=%0d lv=%b want 0 %0d 11",
                  ns, rat, {set_level, rst_level}, LAT);
      end
      idle(12, "simultaneous");
   endtask

   task automatic test_staggered();
      int sat = -1, rat = -1;
      for (int k = 1; k <= 25; k++) begin
         step(1, k >= 11);
         if (set_pulse && sat < 0) sat = k;
         if (rst_pulse && rat < 0) rat = k;
         checks++;
         if ({set_pulse, rst_pulse, set_level, rst_level} !== {m_set, m_rst, m_lvl[0], m_lvl[1]}) begin
            errors++;
            $display("FAIL staggered step=%0d got=%b want=%b", k,
                     {set_pulse, rst_pulse, set_level, rst_level}, {m_set, m_rst, m_lvl[0], m_lvl[1]});
         end
      end
      checks++;
      if (sat !== LAT || rat !== 10 + LAT) begin
         errors++;
         $display("FAIL staggered_edges got set=%0d rst=%0d want set=%0d rst=%0d", sat, rat, LAT, 10 + LAT);
      end
      idle(12, "staggered");
   endtask

   task automatic test_async_reset();
      int at = -1;
      for (int k = 1; k <= 4; k++) step(1, 0);
      #2 rst_n = 0;
      #1;
      checks++;
      if ({set_pulse, rst_pulse, set_level, rst_level} !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset_clear got=%b want=0000", {set_pulse, rst_pulse, set_level, rst_level});
      end
      step(1, 0);
      step(1, 0);
      rst_n = 1;
      for (int k = 1; k <= 12; k++) begin
         step(1, 0);
         if (set_pulse && at < 0) at = k;
         checks++;
         if ({set_pulse, rst_pulse, set_level, rst_level} !== {m_set, m_rst, m_lvl[0], m_lvl[1]}) begin
            errors++;
            $display("FAIL async_reset step=%0d got=%b want=%b", k,
                     {set_pulse, rst_pulse, set_level, rst_level}, {m_set, m_rst, m_lvl[0], m_lvl[1]});
         end
      end
      checks++;
      if (at !== LAT) begin
         errors++;
         $display("FAIL async_reset_latency got edge=%0d want edge=%0d", at, LAT);
      end
      idle(12, "async_reset");
   endtask

   task automatic test_random();
      bit v[2];
      int seg[2] = '{0, 0};
      for (int k = 1; k <= 600; k++) begin
         if ($urandom_range(0, 29) == 0) begin
            v[0] = 1; v[1] = 1; seg[0] = 9; seg[1] = 9;
         end
         for (int i = 0; i < 2; i++) begin
            if (seg[i] == 0) begin
               v[i]   = 1'($urandom_range(0, 1));
               seg[i] = $urandom_range(1, 10);
            end
            seg[i]--;
         end
         if (k % 200 == 150) begin
            #2 rst_n = 0;
            #1;
            checks++;
            if ({set_pulse, rst_pulse, set_level, rst_level} !== 4'b0000) begin
               errors++;
               $display("FAIL random_reset step=%0d got=%b want=0000", k,
                        {set_pulse, rst_pulse, set_level, rst_level});
            end
            step(v[0], v[1]);
            rst_n = 1;
         end
         step(v[0], v[1]);
         checks++;
         if ({set_pulse, rst_pulse, set_level, rst_level} !== {m_set, m_rst, m_lvl[0], m_lvl[1]}) begin
            errors++;
            $display("FAIL random step=%0d got=%b want=%b", k,
                     {set_pulse, rst_pulse, set_level, rst_level}, {m_set, m_rst, m_lvl[0], m_lvl[1]});
         end
`ifdef SR_CONFLICT_FLAG_EN
         checks++;
         if (conflict !== m_conf) begin
            errors++;
            $display("FAIL random_conflict step=%0d got=%b want=%b", k, conflict, m_conf);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_glitch();
      test_simultaneous();
      test_staggered();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
